// File: rtl/bp_common_pkg.sv
// Shared types and sizing helpers for the test-top sequencer and its watchdogs.
// No datapath latency and no flow control: declarations only.
package bp_common_pkg;

    typedef enum logic [1:0] {e_hold, e_release, e_run, e_done} bp_test_seq_state_e;

    // Counter width that is never zero, even for a limit of 0 or 1.
    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/bp_nonsynth_watchdog.sv
// Per-core stall watchdog: counts cycles without a kick, saturating at stall_cycles_p.
// fired_o is combinational from this cycle's kick/freeze, so it flags on the reaching cycle.
// No backpressure; a freeze holds the count and masks fired_o.
module bp_nonsynth_watchdog
    import bp_common_pkg::*;
#(
    parameter int stall_cycles_p = 4096
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic kick_i,
    input  logic freeze_i,
    output logic fired_o
);

    localparam int cnt_width_lp = safe_clog2(stall_cycles_p + 1);
    localparam logic [cnt_width_lp-1:0] stall_lp = cnt_width_lp'(stall_cycles_p);

    logic [cnt_width_lp-1:0] cnt_r;
    logic [cnt_width_lp-1:0] cnt_n;

    always_comb begin
        cnt_n = cnt_r;
        if (freeze_i) begin
            cnt_n = cnt_r;
        end else if (kick_i) begin
            cnt_n = '0;
        end else if (cnt_r != stall_lp) begin
            cnt_n = cnt_r + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_n;
        end
    end

    assign fired_o = ~freeze_i & (cnt_n == stall_lp);

endmodule

// File: rtl/bp_nonsynth_test_sequencer.sv
// Multi-core bench sequencer: staggered per-core reset release, done/pass capture, watchdogs, sticky verdict.
// Verdict registers one edge after the deciding e_run cycle; reset release is registered per core.
// No backpressure: done strobes are single-cycle and only the first per core is taken.
module bp_nonsynth_test_sequencer
    import bp_common_pkg::*;
#(
    parameter int core_els_p          = 1,
    parameter int reset_hold_cycles_p = 16,
    parameter int stagger_cycles_p    = 4,
    parameter int stall_cycles_p      = 4096,
    parameter int timeout_cycles_p    = 1000000,
    parameter int stop_on_fail_p      = 1,
    localparam int core_id_width_lp   = safe_clog2(core_els_p)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    output logic [core_els_p-1:0]       core_reset_o,
    input  logic [core_els_p-1:0]       commit_v_i,
    input  logic [core_els_p-1:0]       core_done_i,
    input  logic [core_els_p-1:0]       core_pass_i,
    output logic                        finish_o,
    output logic                        pass_o,
    output logic                        timeout_o,
    output logic [core_id_width_lp-1:0] fail_core_id_o,
    output logic [63:0]                 cycle_count_o
);

    localparam int hold_width_lp = safe_clog2(reset_hold_cycles_p + 1);
    localparam int stag_width_lp = safe_clog2(stagger_cycles_p + 1);

    bp_test_seq_state_e state_r, state_n;

    logic [hold_width_lp-1:0]    hold_cnt_r;
    logic [stag_width_lp-1:0]    stag_cnt_r;
    logic [core_id_width_lp-1:0] rel_idx_r;
    logic [core_els_p-1:0]       core_reset_r, core_reset_n;
    logic [core_els_p-1:0]       done_r, done_n, pass_r, pass_n, newly_done, fired;
    logic                        hold_done, rel_fire, rel_last, running, global_to;
    logic                        term, term_pass, term_to;
    logic [core_id_width_lp-1:0] term_id;

    function automatic logic [core_id_width_lp-1:0] lowest_set(input logic [core_els_p-1:0] v);
        logic [core_id_width_lp-1:0] r;
        r = '0;
        for (int i = core_els_p - 1; i >= 0; i--) begin
            if (v[i]) r = core_id_width_lp'(i);
        end
        return r;
    endfunction

    assign running   = (state_r == e_run);
    assign hold_done = (state_r == e_hold) && ((int'(hold_cnt_r) + 1) >= reset_hold_cycles_p);
    assign rel_fire  = hold_done
                     || ((state_r == e_release) && ((int'(stag_cnt_r) + 1) >= stagger_cycles_p));
    assign rel_last  = (stagger_cycles_p == 0) || (rel_idx_r == core_id_width_lp'(core_els_p - 1));
    assign global_to = (cycle_count_o >= 64'(timeout_cycles_p));

    // Done/pass latches see this cycle's strobes so termination can act on them immediately.
    assign done_n     = done_r | ({core_els_p{running}} & core_done_i & ~core_reset_r);
    assign newly_done = done_n & ~done_r;
    assign pass_n     = (pass_r & ~newly_done) | (core_pass_i & newly_done);

    always_comb begin
        core_reset_n = core_reset_r;
        if (rel_fire) begin
            if (stagger_cycles_p == 0) core_reset_n = '0;
            else                       core_reset_n[rel_idx_r] = 1'b0;
        end
    end

    for (genvar i = 0; i < core_els_p; i++) begin : g_wd
        bp_nonsynth_watchdog #(.stall_cycles_p(stall_cycles_p)) u_wd (
            .clk_i    (clk_i),
            .reset_i  (reset_i),
            .kick_i   (commit_v_i[i] | ~running),
            .freeze_i (done_n[i]),
            .fired_o  (fired[i])
        );
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_r <= e_hold;
        else         state_r <= state_n;
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            e_hold:    if (hold_done) state_n = rel_last ? e_run : e_release;
            e_release: if (rel_fire && rel_last) state_n = e_run;
            e_run:     if (term) state_n = e_done;
            default:   state_n = e_done;
        endcase
    end

    // Termination precedence: completion, stop-on-fail, watchdog, global timeout.
    always_comb begin
        term      = 1'b0;
        term_pass = 1'b0;
        term_to   = 1'b0;
        term_id   = '0;
        if (running) begin
            if (&done_n) begin
                term      = 1'b1;
                term_pass = &pass_n;
                term_id   = lowest_set(~pass_n);
            end else if ((stop_on_fail_p != 0) && |(newly_done & ~pass_n)) begin
                term    = 1'b1;
                term_id = lowest_set(newly_done & ~pass_n);
            end else if (|fired) begin
                term    = 1'b1;
                term_to = 1'b1;
                term_id = lowest_set(fired);
            end else if (global_to) begin
                term    = 1'b1;
                term_to = 1'b1;
                term_id = lowest_set(~done_n);
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            core_reset_r   <= '1;
            hold_cnt_r     <= '0;
            stag_cnt_r     <= '0;
            rel_idx_r      <= '0;
            done_r         <= '0;
            pass_r         <= '0;
            cycle_count_o  <= '0;
            finish_o       <= 1'b0;
            pass_o         <= 1'b0;
            timeout_o      <= 1'b0;
            fail_core_id_o <= '0;
        end else begin
            core_reset_r <= core_reset_n;
            done_r       <= done_n;
            pass_r       <= pass_n;
            if (state_r == e_hold) hold_cnt_r <= hold_cnt_r + 1'b1;
            if (rel_fire)                    stag_cnt_r <= '0;
            else if (state_r == e_release)   stag_cnt_r <= stag_cnt_r + 1'b1;
            if (rel_fire && !rel_last)       rel_idx_r  <= rel_idx_r + 1'b1;
            if (running && !(&cycle_count_o)) cycle_count_o <= cycle_count_o + 64'd1;
            if (term) begin
                finish_o       <= 1'b1;
                pass_o         <= term_pass;
                timeout_o      <= term_to;
                fail_core_id_o <= term_id;
            end
        end
    end

    assign core_reset_o = core_reset_r;

endmodule
